param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
- Parametrised successor to the 16x16 ALU register file: configurable width, depth and read-port count.
- Adds an optional hardwired zero register, optional write-to-read forwarding, and a hardware clear sequencer that zeroes the array after reset or on command.
- Sits between the instruction decoder/write-back stage and the ALU operand inputs.
- Reads stay combinational; writes are synchronous.

Parameters:
- DATA_W, 16, register width in bits.
- DEPTH, 16, number of registers (power of two, at least 2).
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).
- NUM_RD, 2, number of independent read ports.
- ZERO_REG, 0: if 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: if 1, an accepted same-cycle write is forwarded to matching read ports.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- W_data  in  DATA_W  write data.
- W_addr  in  ADDR_W  write address.
- W_wr  in  1  write request.
- W_rdy  out  1  write accepted this cycle when W_wr && W_rdy.
- R_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- R_data  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
- CLR_start  in  1  single-cycle request to zero all registers.
- CLR_busy  out  1  clear sweep in progress.
- CLR_done  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Clock and reset: one clock (CLK); reset RST_N is asynchronous and active-low.
- Reset assertion: FSM forced to CLEAR, sweep pointer to 0, CLR_done 0. CLR_busy goes 1 and W_rdy goes 0 immediately (asynchronously). The array itself is not reset.
- Reset release: the sweep runs automatically from address 0.
- FSM states:
  - IDLE to CLEAR when CLR_start=1.
  - CLEAR writes 0 to the address held in the sweep pointer each cycle, then increments it.
  - CLEAR to IDLE on the cycle that writes address DEPTH-1; CLR_done=1 on the following cycle only.
- Sweep length: exactly DEPTH cycles. CLR_busy=1 for DEPTH cycles, starting the cycle after CLR_start is sampled.
- CLR_start while CLEAR: ignored; the sweep is not restarted.
- RST_N asserted mid-sweep: sweep restarts from 0 after release; no CLR_done for the aborted sweep.
- W_rdy = (state==IDLE) && !CLR_start. Consequences:
  - A write during a sweep is dropped.
  - CLR_start and W_wr in the same IDLE cycle: the clear wins and the write is dropped.
- Accepted write: regfile[W_addr] <= W_data at the rising edge. If ZERO_REG=1 and W_addr==0, the write is discarded (W_rdy still reflects the FSM state).
- Reads, port i, combinational, priority order:
  1. CLR_busy=1 gives 0.
  2. ZERO_REG=1 and address 0 gives 0.
  3. BYPASS=1, write accepted this cycle, W_addr==R_addr[i] (and not the discarded zero-register case) gives W_data.
  4. Otherwise regfile[R_addr[i]].
- Multiple ports at the same address return identical data.
- BYPASS=0: a written value becomes visible on reads the cycle after the write edge.
- Width rules: no truncation or extension. The address range is exactly DEPTH, so there are no out-of-range addresses.
- Output values after reset: W_rdy=0, CLR_busy=1, CLR_done=0, all R_data=0 until the sweep completes.

Decomposition:
- Shared package rf_pkg:
  - typedef enum {RF_IDLE, RF_CLEAR} rf_state_t.
  - Default constants RF_DATA_W=16 and RF_DEPTH=16.
- Sub-module rf_clear_seq: the FSM, sweep counter, CLR_busy/CLR_done generation and W_rdy gating.
- Top level keeps the array, the write mux (sweep write vs user write) and the NUM_RD read/bypass generate loop.

Test Plan:
- Reset release with DEPTH=16: CLR_busy=1 for 16 cycles, CLR_done pulses once at cycle 17, all R_data read 0, W_rdy=1 afterwards.
- Write 0xBEEF to reg 5, then 0x1234 to reg 9. The next cycle, read port 0 at 5 gives 0xBEEF and port 1 at 9 gives 0x1234; both ports at 5 return 0xBEEF.
- BYPASS=1: W_wr to reg 3 with 0xA5A5 while R_addr[0]=3 gives R_data[0]=0xA5A5 in the same cycle. With BYPASS=0, the old value is seen that cycle and 0xA5A5 the next.
- ZERO_REG=1: write 0xFFFF to reg 0, then read reg 0 gives 0x0000; a write to reg 1 is unaffected.
- CLR_start together with W_wr (reg 2, 0x7777): W_rdy=0, the write is dropped. After CLR_done, reg 2 reads 0. A CLR_start at sweep cycle 8 does not extend the sweep beyond 16 cycles.
- Drop RST_N at sweep cycle 6: CLR_busy stays 1. After release, a full 16-cycle sweep runs and exactly one CLR_done pulse is seen.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the parametrised register file.
// Imported by the clear sequencer and the register file top level.
package rf_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 16;
    localparam int RF_DEPTH  = 16;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: sweeps zeros across the array after reset or on request.
// It also gates write acceptance so that a sweep can never race a user write.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR_start,
    output logic              CLR_busy,
    output logic              CLR_done,
    output logic              W_rdy,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              done_reg, done_next;

    // Reset parks the FSM in CLEAR, so a sweep starts as soon as reset is released.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= RF_CLEAR;
            ptr_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        done_next  = 1'b0;
        case (state_reg)
            RF_IDLE: begin
                if (CLR_start) begin
                    state_next = RF_CLEAR;
                    ptr_next   = '0;
                end
            end
            RF_CLEAR: begin
                // DEPTH is a power of two, so the pointer wraps back to 0 here.
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == LAST_ADDR) begin
                    state_next = RF_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = RF_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign CLR_busy   = (state_reg == RF_CLEAR);
    assign CLR_done   = done_reg;
    assign W_rdy      = (state_reg == RF_IDLE) && !CLR_start;
    assign sweep_addr = ptr_reg;

endmodule

// File: rtl/param_register_file.sv
// Parametrised multi-read-port register file with combinational reads and
// synchronous writes, an optional zero register, optional bypass and a hardware clear sweep.
module param_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [DATA_W-1:0]        W_data,
    input  logic [ADDR_W-1:0]        W_addr,
    input  logic                     W_wr,
    output logic                     W_rdy,
    input  logic [NUM_RD*ADDR_W-1:0] R_addr,
    output logic [NUM_RD*DATA_W-1:0] R_data,
    input  logic                     CLR_start,
    output logic                     CLR_busy,
    output logic                     CLR_done
);

    logic [DATA_W-1:0] regfile [DEPTH];

    logic [ADDR_W-1:0] sweep_addr;
    logic              zero_hit_w;
    logic              user_wr;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;

    rf_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CLR_start  (CLR_start),
        .CLR_busy   (CLR_busy),
        .CLR_done   (CLR_done),
        .W_rdy      (W_rdy),
        .sweep_addr (sweep_addr)
    );

    // A user write that targets the hardwired zero register is accepted but discarded.
    assign zero_hit_w = (ZERO_REG != 0) && (W_addr == '0);
    assign user_wr    = W_wr && W_rdy && !zero_hit_w;

    always_comb begin
        arr_we   = 1'b0;
        arr_addr = W_addr;
        arr_data = W_data;
        if (CLR_busy) begin
            arr_we   = 1'b1;
            arr_addr = sweep_addr;
            arr_data = '0;
        end else if (user_wr) begin
            arr_we = 1'b1;
        end
    end

    // The array is deliberately left out of reset; the sweep clears it instead.
    always_ff @(posedge CLK) begin
        if (arr_we) begin
            regfile[arr_addr] <= arr_data;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;

        assign rd_addr = R_addr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            if (CLR_busy) begin
                rd_data = '0;
            end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_data = '0;
            end else if ((BYPASS != 0) && user_wr && (W_addr == rd_addr)) begin
                rd_data = W_data;
            end else begin
                rd_data = regfile[rd_addr];
            end
        end

        assign R_data[gi*DATA_W +: DATA_W] = rd_data;
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: instance a has bypass and no zero register,
// instance b has the zero register and no bypass; both share one stimulus stream.
module tb_param_register_file;

    logic        clk;
    logic        rst_n;
    logic [15:0] w_data;
    logic [3:0]  w_addr;
    logic        w_wr;
    logic [7:0]  r_addr;
    logic        clr_start;

    logic        rdy_a, busy_a, done_a;
    logic        rdy_b, busy_b, done_b;
    logic [31:0] r_data_a, r_data_b;

    int tests_run    = 0;
    int tests_failed = 0;

    int busy_cnt, done_cnt, done_idx, zero_bad;

    param_register_file #(
        .DATA_W(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)
    ) dut_a (
        .CLK(clk), .RST_N(rst_n), .W_data(w_data), .W_addr(w_addr), .W_wr(w_wr),
        .W_rdy(rdy_a), .R_addr(r_addr), .R_data(r_data_a), .CLR_start(clr_start),
        .CLR_busy(busy_a), .CLR_done(done_a)
    );

    param_register_file #(
        .DATA_W(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n), .W_data(w_data), .W_addr(w_addr), .W_wr(w_wr),
        .W_rdy(rdy_b), .R_addr(r_addr), .R_data(r_data_b), .CLR_start(clr_start),
        .CLR_busy(busy_b), .CLR_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b1; w_wr = 1'b0; w_addr = '0; w_data = '0; r_addr = 8'h70; clr_start = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            tests_failed++; $display("FAIL reset_busy: got a=%b b=%b expected 1", busy_a, busy_b);
        end
        tests_run++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || done_a !== 1'b0 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rdy_done: got rdy=%b%b done=%b%b expected 00 00", rdy_a, rdy_b, done_a, done_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_idx = -1; zero_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (busy_a) busy_cnt++;
            if (busy_a !== busy_b) zero_bad++;
            if (done_a) begin done_cnt++; done_idx = i; end
            if (busy_a && (r_data_a !== 32'h0 || r_data_b !== 32'h0)) zero_bad++;
        end
        tests_run++;
        if (busy_cnt != 16) begin
            tests_failed++; $display("FAIL reset_sweep_len: got %0d expected 16", busy_cnt);
        end
        tests_run++;
        if (done_cnt != 1 || done_idx != 16) begin
            tests_failed++; $display("FAIL reset_done_pulse: got count=%0d at=%0d expected 1 at 16", done_cnt, done_idx);
        end
        tests_run++;
        if (zero_bad != 0) begin
            tests_failed++; $display("FAIL reset_read_zero: got %0d bad samples expected 0", zero_bad);
        end
        tests_run++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || r_data_a !== 32'h0 || r_data_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_after: got rdy=%b%b a=%h b=%h expected 11 0 0", rdy_a, rdy_b, r_data_a, r_data_b);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk); w_wr = 1'b1; w_addr = 4'd5; w_data = 16'hBEEF;
        #1;
        tests_run++;
        if (rdy_a !== 1'b1) begin
            tests_failed++; $display("FAIL write_rdy: got %b expected 1", rdy_a);
        end
        @(negedge clk); w_addr = 4'd9; w_data = 16'h1234;
        @(negedge clk); w_wr = 1'b0; r_addr = {4'd9, 4'd5};
        #1;
        tests_run++;
        if (r_data_a !== 32'h1234_BEEF || r_data_b !== 32'h1234_BEEF) begin
            tests_failed++; $display("FAIL read_5_9: got a=%h b=%h expected 1234beef", r_data_a, r_data_b);
        end
        @(negedge clk); r_addr = {4'd5, 4'd5};
        #1;
        tests_run++;
        if (r_data_a !== 32'hBEEF_BEEF || r_data_b !== 32'hBEEF_BEEF) begin
            tests_failed++; $display("FAIL read_same_addr: got a=%h b=%h expected beefbeef", r_data_a, r_data_b);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk); w_wr = 1'b1; w_addr = 4'd3; w_data = 16'hA5A5; r_addr = {4'd5, 4'd3};
        #1;
        tests_run++;
        if (r_data_a[15:0] !== 16'hA5A5) begin
            tests_failed++; $display("FAIL bypass_same_cycle: got %h expected a5a5", r_data_a[15:0]);
        end
        tests_run++;
        if (r_data_b[15:0] !== 16'h0000) begin
            tests_failed++; $display("FAIL nobypass_same_cycle: got %h expected 0000", r_data_b[15:0]);
        end
        @(negedge clk); w_wr = 1'b0;
        #1;
        tests_run++;
        if (r_data_a[15:0] !== 16'hA5A5 || r_data_b[15:0] !== 16'hA5A5) begin
            tests_failed++; $display("FAIL bypass_next_cycle: got a=%h b=%h expected a5a5", r_data_a[15:0], r_data_b[15:0]);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk); w_wr = 1'b1; w_addr = 4'd0; w_data = 16'hFFFF; r_addr = {4'd1, 4'd0};
        #1;
        tests_run++;
        if (r_data_a[15:0] !== 16'hFFFF || r_data_b[15:0] !== 16'h0000 || rdy_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_write_cycle: got a=%h b=%h rdy_b=%b expected ffff 0000 1", r_data_a[15:0], r_data_b[15:0], rdy_b);
        end
        @(negedge clk); w_addr = 4'd1; w_data = 16'h0101;
        #1;
        tests_run++;
        if (r_data_a !== 32'h0101_FFFF || r_data_b !== 32'h0000_0000) begin
            tests_failed++; $display("FAIL zero_read_back: got a=%h b=%h expected 0101ffff 00000000", r_data_a, r_data_b);
        end
        @(negedge clk); w_wr = 1'b0;
        #1;
        tests_run++;
        if (r_data_a !== 32'h0101_FFFF || r_data_b !== 32'h0101_0000) begin
            tests_failed++; $display("FAIL zero_reg1: got a=%h b=%h expected 0101ffff 01010000", r_data_a, r_data_b);
        end
    endtask

    task automatic test_clear_cmd();
        @(negedge clk); clr_start = 1'b1; w_wr = 1'b1; w_addr = 4'd2; w_data = 16'h7777; r_addr = {4'd3, 4'd2};
        #1;
        tests_run++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || r_data_a[15:0] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL clear_blocks_write: got rdy=%b%b r=%h expected 00 0000", rdy_a, rdy_b, r_data_a[15:0]);
        end
        busy_cnt = 0; done_cnt = 0; done_idx = -1; zero_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            w_wr = 1'b0;
            clr_start = (i == 7);
            #1;
            if (busy_a) busy_cnt++;
            if (busy_a !== busy_b) zero_bad++;
            if (done_a) begin done_cnt++; done_idx = i; end
            if (busy_a && (r_data_a !== 32'h0 || r_data_b !== 32'h0)) zero_bad++;
        end
        tests_run++;
        if (busy_cnt != 16) begin
            tests_failed++; $display("FAIL clear_sweep_len: got %0d expected 16", busy_cnt);
        end
        tests_run++;
        if (done_cnt != 1 || done_idx != 16 || zero_bad != 0) begin
            tests_failed++;
            $display("FAIL clear_done: got count=%0d at=%0d bad=%0d expected 1 at 16 bad 0", done_cnt, done_idx, zero_bad);
        end
        tests_run++;
        if (r_data_a !== 32'h0 || r_data_b !== 32'h0) begin
            tests_failed++; $display("FAIL clear_regs_zero: got a=%h b=%h expected 0", r_data_a, r_data_b);
        end
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk); w_wr = 1'b1; w_addr = 4'd4; w_data = 16'h4444; r_addr = {4'd4, 4'd4};
        @(negedge clk); w_wr = 1'b0;
        #1;
        tests_run++;
        if (r_data_a !== 32'h4444_4444 || r_data_b !== 32'h4444_4444) begin
            tests_failed++; $display("FAIL midrst_prewrite: got a=%h b=%h expected 44444444", r_data_a, r_data_b);
        end
        clr_start = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr_start = 1'b0;
            if (i == 5) rst_n = 1'b0;
            #1;
            if (done_a || done_b) done_cnt++;
        end
        tests_run++;
        if (busy_a !== 1'b1 || rdy_a !== 1'b0 || done_cnt != 0) begin
            tests_failed++; $display("FAIL midrst_assert: got busy=%b rdy=%b dones=%0d expected 1 0 0", busy_a, rdy_a, done_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (busy_a) busy_cnt++;
            if (done_a) begin done_cnt++; done_idx = i; end
        end
        tests_run++;
        if (busy_cnt != 16 || done_cnt != 1 || done_idx != 16) begin
            tests_failed++;
            $display("FAIL midrst_sweep: got busy=%0d dones=%0d at=%0d expected 16 1 at 16", busy_cnt, done_cnt, done_idx);
        end
        tests_run++;
        if (r_data_a !== 32'h0 || r_data_b !== 32'h0) begin
            tests_failed++; $display("FAIL midrst_cleared: got a=%h b=%h expected 0", r_data_a, r_data_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear_cmd();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
